// File: rtl/fpga_mem_pkg.sv
// Shared types and default geometry for the cache-line to BRAM bridge.
package fpga_mem_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int BUS_W_DEF   = 32;
   localparam int LINE_W_DEF  = 256;
   localparam int TIMEOUT_DEF = 4096;

   // Beats per line and byte-offset bits of a line address at the default geometry.
   localparam int BEATS    = LINE_W_DEF / BUS_W_DEF;
   localparam int OFFSET_W = $clog2(LINE_W_DEF / 8);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_ADDR,
      ST_SEND_DATA,
      ST_WAIT_WACK,
      ST_WAIT_RDATA,
      ST_RESP
   } fpga_ctrl_state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [LINE_W_DEF-1:0] wdata;
   } line_req_t;

endpackage

// File: rtl/fpga_line_shift.sv
// Line register organised as BEATS slots of BUS_W bits. Loads a whole line,
// writes one slot by index (deserialize) and reads one slot by index (serialize).
module fpga_line_shift #(
   parameter int BUS_W = 32,
   parameter int BEATS = 8,
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [BEATS*BUS_W-1:0] load_data,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [BUS_W-1:0]       wr_data,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [BUS_W-1:0]       rd_data,
   output logic [BEATS*BUS_W-1:0] line
);

   logic [BEATS-1:0][BUS_W-1:0] slots;

   // Whole-line load has priority over a single-slot write.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: this array is reset because it drives rsp_rdata directly and every
      // output must read 0 out of reset; a pure data buffer would normally skip it.
      if (rst) begin
         slots <= '0;
      end else if (load) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         slots <= load_data;
      end else if (wr_en) begin
         slots[wr_idx] <= wr_data;
      end
   end

   assign rd_data = slots[rd_idx];
   assign line    = slots;

endmodule

// File: rtl/fpga_bram_ctrl.sv
// Bridges one cache-line request at a time onto the narrow shared BRAM bus:
// address beat, optional write-data beats, then waits for ack or read beats.
module fpga_bram_ctrl
   import fpga_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int BUS_W       = BUS_W_DEF,
   parameter int LINE_W      = LINE_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic              rsp_err,
   output logic [LINE_W-1:0] rsp_rdata,
   output logic [BUS_W-1:0]  address_data_bus_c_to_m,
   output logic              address_on_c_to_m,
   output logic              data_on_c_to_m,
   output logic              read_en_c_to_m,
   output logic              write_en_c_to_m,
   input  logic [BUS_W-1:0]  address_data_bus_m_to_c,
   input  logic              resp_m_to_c,
   output logic              proto_err
);

   localparam int LINE_BEATS = LINE_W / BUS_W;
   localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam int WAIT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

   fpga_ctrl_state_t state, next_state;

   logic [BEAT_W-1:0] beat_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              write_q;

   logic              handshake;
   logic              in_wait;
   logic              timeout_hit;
   logic              last_beat;
   logic              slot_wr;
   logic [BEAT_W-1:0] rd_idx;
   logic [BUS_W-1:0]  rd_beat;

   // Values the output registers take at the next edge.
   logic [BUS_W-1:0]  bus_d;
   logic              address_on_d, data_on_d, read_en_d, write_en_d;
   logic              req_ready_d, rsp_valid_d, rsp_write_d, rsp_err_d;

   assign handshake   = req_valid & req_ready;
   assign in_wait     = (state == ST_WAIT_WACK) || (state == ST_WAIT_RDATA);
   assign timeout_hit = in_wait && !resp_m_to_c && (wait_cnt == WAIT_LAST);
   assign last_beat   = (beat_cnt == LAST_BEAT);
   assign slot_wr     = (state == ST_WAIT_RDATA) && resp_m_to_c;
   // The bus register is loaded one cycle ahead, so serialize the beat after the current one.
   assign rd_idx      = (state == ST_SEND_DATA) ? beat_cnt + BEAT_W'(1) : '0;

   // One line register serves both directions: loaded with wdata at accept,
   // filled slot by slot with read beats, and presented as rsp_rdata.
   fpga_line_shift #(
      .BUS_W (BUS_W),
      .BEATS (LINE_BEATS)
   ) u_line (
      .clk       (clk),
      .rst       (rst),
      .load      (handshake),
      .load_data (req_wdata),
      .wr_en     (slot_wr),
      .wr_idx    (beat_cnt),
      .wr_data   (address_data_bus_m_to_c),
      .rd_idx    (rd_idx),
      .rd_data   (rd_beat),
      .line      (rsp_rdata)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: defaulting every comb output first guarantees no path leaves it
      // unassigned, which is what would otherwise infer a latch.
      next_state = state;
      case (state)
         ST_IDLE:       if (handshake) next_state = ST_SEND_ADDR;
         ST_SEND_ADDR:  next_state = write_q ? ST_SEND_DATA : ST_WAIT_RDATA;
         ST_SEND_DATA:  if (last_beat) next_state = ST_WAIT_WACK;
         ST_WAIT_WACK:  if (resp_m_to_c || timeout_hit) next_state = ST_RESP;
         ST_WAIT_RDATA: if ((resp_m_to_c && last_beat) || timeout_hit) next_state = ST_RESP;
         ST_RESP:       next_state = ST_IDLE;
         default:       next_state = ST_IDLE;
      endcase
   end

   // Output decode from the state being entered, so registered outputs line up with it.
   always_comb begin
      bus_d        = '0;
      address_on_d = 1'b0;
      data_on_d    = 1'b0;
      read_en_d    = 1'b0;
      write_en_d   = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_write_d  = 1'b0;
      rsp_err_d    = 1'b0;
      req_ready_d  = (next_state == ST_IDLE);
      case (next_state)
         ST_SEND_ADDR: begin
            // SEND_ADDR is only entered on a handshake, so the request ports are live here.
            bus_d        = BUS_W'(req_addr & LINE_MASK);
            address_on_d = 1'b1;
            read_en_d    = !req_write;
            write_en_d   = req_write;
         end
         ST_SEND_DATA: begin
            bus_d     = rd_beat;
            data_on_d = 1'b1;
         end
         ST_RESP: begin
            rsp_valid_d = 1'b1;
            rsp_write_d = write_q;
            rsp_err_d   = timeout_hit;
         end
         default: ;
      endcase
   end

   // Output registers; proto_err is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address_data_bus_c_to_m <= '0;
         address_on_c_to_m       <= 1'b0;
         data_on_c_to_m          <= 1'b0;
         read_en_c_to_m          <= 1'b0;
         write_en_c_to_m         <= 1'b0;
         req_ready               <= 1'b0;
         rsp_valid               <= 1'b0;
         rsp_write               <= 1'b0;
         rsp_err                 <= 1'b0;
         proto_err               <= 1'b0;
      end else begin
         address_data_bus_c_to_m <= bus_d;
         address_on_c_to_m       <= address_on_d;
         data_on_c_to_m          <= data_on_d;
         read_en_c_to_m          <= read_en_d;
         write_en_c_to_m         <= write_en_d;
         req_ready               <= req_ready_d;
         rsp_valid               <= rsp_valid_d;
         rsp_write               <= rsp_write_d;
         rsp_err                 <= rsp_err_d;
         if (resp_m_to_c && (state == ST_IDLE || state == ST_SEND_ADDR || state == ST_SEND_DATA))
            proto_err <= 1'b1;
      end
   end

   // Beat index, wait-timeout counter and captured request type.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         wait_cnt <= '0;
         write_q  <= 1'b0;
      end else begin
         if (handshake) write_q <= req_write;

         if (next_state != state)
            beat_cnt <= '0;
         else if (state == ST_SEND_DATA || slot_wr)
            beat_cnt <= beat_cnt + BEAT_W'(1);

         if (next_state != state || resp_m_to_c)
            wait_cnt <= '0;
         else if (in_wait)
            wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

endmodule

// File: tb/tb_fpga_bram_ctrl.sv
// Self-checking bench for fpga_bram_ctrl: table vectors, hand-written corner
// sequences (timeout, reset mid-write, spurious response) and random traffic.
module tb_fpga_bram_ctrl;
   import fpga_mem_pkg::*;

   localparam int          TIMEOUT    = 4096;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFE0;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [255:0] req_wdata = '0;
   logic         rsp_valid, rsp_write, rsp_err;
   logic [255:0] rsp_rdata;
   logic [31:0]  bus_out;
   logic         address_on, data_on, read_en, write_en;
   logic [31:0]  bus_in = '0;
   logic         resp = 1'b0;
   logic         proto_err;

   int checks   = 0;
   int failures = 0;
   bit exp_proto = 1'b0;

   fpga_bram_ctrl dut (
      .clk                     (clk),
      .rst                     (rst),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_write               (req_write),
      .req_addr                (req_addr),
      .req_wdata               (req_wdata),
      .rsp_valid               (rsp_valid),
      .rsp_write               (rsp_write),
      .rsp_err                 (rsp_err),
      .rsp_rdata               (rsp_rdata),
      .address_data_bus_c_to_m (bus_out),
      .address_on_c_to_m       (address_on),
      .data_on_c_to_m          (data_on),
      .read_en_c_to_m          (read_en),
      .write_en_c_to_m         (write_en),
      .address_data_bus_m_to_c (bus_in),
      .resp_m_to_c             (resp),
      .proto_err               (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      line_req_t   req;        // for reads, wdata is the line memory returns
      int          delay;      // read: cycles before first beat; write: ack delay; -1 = never
      bit          gapped;     // read beats on alternate cycles
      logic [31:0] exp_abeat;  // expected address beat
      int          exp_lat;    // expected accept-to-rsp_valid cycles
   } vec_t;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] step);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k) * step;
      return l;
   endfunction

   function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] base,
                               input logic [31:0] step, input int delay, input bit gapped,
                               input logic [31:0] exp_abeat, input int exp_lat);
      vec_t v;
      v.req.write  = wr;
      v.req.addr   = addr;
      v.req.wdata  = make_line(base, step);
      v.delay      = delay;
      v.gapped     = gapped;
      v.exp_abeat  = exp_abeat;
      v.exp_lat    = exp_lat;
      return v;
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_wait", 256'(req_ready), 256'(1));
   endtask

   // One full transaction with the bench acting as memory. Cycle 0 is the
   // accept cycle; at the negedge of cycle t the bench observes the outputs of
   // cycle t and drives the memory inputs for cycle t.
   task automatic txn(input string name, input line_req_t rq, input int delay, input bit gapped,
                      input logic [31:0] exp_abeat, input int exp_lat, input bit exp_err);
      bit           ok;
      int           nrsp = 0, rsp_t = -1, kn = 0, bad_strobe = 0;
      int           step = gapped ? 2 : 1;
      logic         rw = 1'bx, re = 1'bx, ready_after = 1'b0;
      logic [255:0] rdata_seen = '0, wline = '0;
      logic [31:0]  wbeats[$];

      wait_ready(ok);
      if (!ok) return;
      req_valid = 1'b1;
      req_write = rq.write;
      req_addr  = rq.addr;
      req_wdata = rq.write ? rq.wdata : ~rq.wdata;
      for (int t = 1; t <= exp_lat + 2; t++) begin
         @(negedge clk);
         req_valid = 1'b0;
         resp      = 1'b0;
         bus_in    = '0;
         if (t == 1)
            check({name, "/abeat"}, {address_on, read_en, write_en, data_on, bus_out},
                  {1'b1, !rq.write, rq.write, 1'b0, exp_abeat});
         if ((int'(address_on) + int'(data_on)) > 1 || ((read_en || write_en) && !address_on))
            bad_strobe++;
         if (data_on) wbeats.push_back(bus_out);
         if (rsp_valid) begin
            nrsp++;
            if (rsp_t < 0) begin
               rsp_t      = t;
               rw         = rsp_write;
               re         = rsp_err;
               rdata_seen = rsp_rdata;
            end
         end
         if (t == exp_lat + 1) ready_after = req_ready;
         if (!rq.write && delay >= 0 && kn < 8 && t == 2 + delay + kn * step) begin
            resp   = 1'b1;
            bus_in = rq.wdata[kn*32 +: 32];
            kn++;
         end
         if (rq.write && delay >= 0 && t == 10 + delay) resp = 1'b1;
      end
      resp = 1'b0;
      check({name, "/rsp_count"}, 256'(nrsp), 256'(1));
      check({name, "/rsp_cycle"}, 256'(rsp_t), 256'(exp_lat));
      check({name, "/rsp_write_err"}, {rw, re}, {rq.write, exp_err});
      if (!rq.write && !exp_err) check({name, "/rdata"}, rdata_seen, rq.wdata);
      if (rq.write) begin
         for (int k = 0; k < wbeats.size() && k < 8; k++) wline[k*32 +: 32] = wbeats[k];
         check({name, "/wbeat_count"}, 256'(wbeats.size()), 256'(8));
         check({name, "/wdata"}, wline, rq.wdata);
      end
      check({name, "/strobes"}, 256'(bad_strobe), 256'(0));
      check({name, "/ready_after"}, 256'(ready_after), 256'(1));
      check({name, "/proto_err"}, 256'(proto_err), 256'(exp_proto));
   endtask

   function automatic logic [255:0] outs_zero_vec();
      return 256'({req_ready, rsp_valid, rsp_write, rsp_err, address_on, data_on,
                   read_en, write_en, proto_err, |rsp_rdata, bus_out});
   endfunction

   initial begin
      vec_t      vecs[6];
      line_req_t rq;
      bit        ok;
      int        seen, delay, lat;
      bit        gapped;

      // Addresses, aligned address beats and latencies derived by hand.
      vecs[0] = mk(0, 32'h0000_1004, 32'h1111_1111, 32'h1111_1111, 0, 0, 32'h0000_1000, 10);
      vecs[1] = mk(1, 32'h0000_2000, 32'h0000_00A0, 32'h0000_0001, 3, 0, 32'h0000_2000, 14);
      vecs[2] = mk(0, 32'h0000_301F, 32'hDEAD_0000, 32'h0000_0003, 0, 1, 32'h0000_3000, 17);
      vecs[3] = mk(0, 32'hFFFF_FFFF, 32'h0102_0304, 32'h1000_0001, 2, 0, 32'hFFFF_FFE0, 12);
      vecs[4] = mk(1, 32'hFFFF_FFE7, 32'h5555_0000, 32'h0F0F_0F0F, 0, 0, 32'hFFFF_FFE0, 11);
      vecs[5] = mk(0, 32'h1234_5678, 32'hCAFE_0000, 32'h0000_0101, 5, 1, 32'h1234_5660, 22);

      // Reset state.
      #1 rst = 1'b1;
      #2 check("reset/outputs", outs_zero_vec(), '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].delay, vecs[i].gapped,
             vecs[i].exp_abeat, vecs[i].exp_lat, 1'b0);

      // Timeout: read with no memory response.
      rq = vecs[0].req;
      txn("timeout", rq, -1, 1'b0, 32'h0000_1000, 2 + TIMEOUT, 1'b1);

      // Reset in the middle of a write, while beat 4 is on the bus.
      wait_ready(ok);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_4000;
      req_wdata = make_line(32'hC0DE_0000, 32'h10);
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      check("rst_mid/beat4", {data_on, bus_out}, {1'b1, 32'hC0DE_0040});
      #1 rst = 1'b1;
      #1 check("rst_mid/outputs_zero", outs_zero_vec(), '0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int t = 0; t < 15; t++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("rst_mid/no_rsp", 256'(seen), 256'(0));
      txn("after_rst", vecs[2].req, 1, 1'b1, 32'h0000_3000, 18, 1'b0);

      // Spurious response in IDLE sets the sticky error; traffic still works.
      wait_ready(ok);
      resp = 1'b1;
      @(negedge clk);
      resp = 1'b0;
      check("spurious/proto_err", 256'(proto_err), 256'(1));
      exp_proto = 1'b1;
      txn("after_spur", vecs[0].req, 0, 1'b0, 32'h0000_1000, 10, 1'b0);

      // Random traffic against the cycle/line model.
      for (int i = 0; i < 20; i++) begin
         rq.write = 1'($urandom_range(0, 1));
         rq.addr  = $urandom;
         for (int k = 0; k < 8; k++) rq.wdata[k*32 +: 32] = $urandom;
         delay  = int'($urandom_range(0, 4));
         gapped = 1'($urandom_range(0, 1));
         lat    = rq.write ? 11 + delay : 3 + delay + 7 * (gapped ? 2 : 1);
         txn($sformatf("rand%0d", i), rq, delay, gapped, rq.addr & ALIGN_MASK, lat, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
